// File: rtl/mem_word_assembler_if.sv
// Request, RAM and completion signals of the halfword-RAM word assembler.
// The assembler itself uses the slave view; whoever drives requests and models the RAM uses the master view.
interface mem_word_assembler_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_byte_addr;
    logic              req_little_endian;
    logic [ADDR_W-2:0] mem_addr;
    logic              mem_rd_en;
    logic [15:0]       mem_read_data;
    logic [31:0]       word_data;
    logic              word_valid;
    logic              word_misaligned;
    logic              busy;

    modport slave (
        input  req_valid, req_byte_addr, req_little_endian, mem_read_data,
        output req_ready, mem_addr, mem_rd_en, word_data, word_valid, word_misaligned, busy
    );

    modport master (
        output req_valid, req_byte_addr, req_little_endian, mem_read_data,
        input  req_ready, mem_addr, mem_rd_en, word_data, word_valid, word_misaligned, busy
    );
endinterface

// File: rtl/mem_word_assembler.sv
// Issues 2 (aligned) or 3 (odd address) halfword reads and assembles the addressed
// 4 bytes into a big- or little-endian 32-bit word, tolerating MEM_LAT cycles of RAM latency.
module mem_word_assembler #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input logic                 clk,
    input logic                 rst,
    mem_word_assembler_if.slave io_bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} stateT;

    stateT             r_state;
    logic              r_offset;
    logic              r_littleEndian;
    logic [1:0]        r_lastIdx;
    logic [1:0]        r_issueIdx;
    logic [15:0]       r_hw0;
    logic [15:0]       r_hw1;
    logic [15:0]       r_hw2;
    logic              r_tagValid [MEM_LAT];
    logic [1:0]        r_tagIdx   [MEM_LAT];
    logic              r_reqReady;
    logic [ADDR_W-2:0] r_memAddr;
    logic              r_memRdEn;
    logic [31:0]       r_wordData;
    logic              r_wordValid;
    logic              r_wordMisaligned;
    logic              r_busy;

    logic              w_capValid;
    logic [1:0]        w_capIdx;
    logic              w_lastCapture;
    logic [15:0]       w_hw0;
    logic [15:0]       w_hw1;
    logic [15:0]       w_hw2;
    logic [47:0]       w_stream;
    logic [31:0]       w_beWord;
    logic [31:0]       w_leWord;

    // The oldest tag stage names the halfword arriving on mem_read_data this cycle.
    assign w_capValid    = r_tagValid[MEM_LAT-1];
    assign w_capIdx      = r_tagIdx[MEM_LAT-1];
    assign w_lastCapture = w_capValid && (w_capIdx == r_lastIdx);

    // Bypass the arriving halfword so the word is complete on the very edge of its last capture.
    assign w_hw0    = (w_capValid && w_capIdx == 2'd0) ? io_bus.mem_read_data : r_hw0;
    assign w_hw1    = (w_capValid && w_capIdx == 2'd1) ? io_bus.mem_read_data : r_hw1;
    assign w_hw2    = (w_capValid && w_capIdx == 2'd2) ? io_bus.mem_read_data : r_hw2;
    assign w_stream = {w_hw0, w_hw1, w_hw2};
    assign w_beWord = r_offset ? w_stream[39:8] : w_stream[47:16];
    assign w_leWord = {w_beWord[7:0], w_beWord[15:8], w_beWord[23:16], w_beWord[31:24]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_offset         <= 1'b0;
            r_littleEndian   <= 1'b0;
            r_lastIdx        <= 2'd0;
            r_issueIdx       <= 2'd0;
            r_hw0            <= '0;
            r_hw1            <= '0;
            r_hw2            <= '0;
            for (int j = 0; j < MEM_LAT; j++) begin
                r_tagValid[j] <= 1'b0;
                r_tagIdx[j]   <= 2'd0;
            end
            r_reqReady       <= 1'b1;
            r_memAddr        <= '0;
            r_memRdEn        <= 1'b0;
            r_wordData       <= '0;
            r_wordValid      <= 1'b0;
            r_wordMisaligned <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_tagValid[0] <= r_memRdEn;
            r_tagIdx[0]   <= r_issueIdx;
            for (int j = 1; j < MEM_LAT; j++) begin
                r_tagValid[j] <= r_tagValid[j-1];
                r_tagIdx[j]   <= r_tagIdx[j-1];
            end

            if (w_capValid) begin
                case (w_capIdx)
                    2'd0:    r_hw0 <= io_bus.mem_read_data;
                    2'd1:    r_hw1 <= io_bus.mem_read_data;
                    default: r_hw2 <= io_bus.mem_read_data;
                endcase
            end

            case (r_state)
                IDLE: begin
                    if (io_bus.req_valid && r_reqReady) begin
                        r_offset       <= io_bus.req_byte_addr[0];
                        r_littleEndian <= io_bus.req_little_endian;
                        r_lastIdx      <= io_bus.req_byte_addr[0] ? 2'd2 : 2'd1;
                        r_issueIdx     <= 2'd0;
                        r_memAddr      <= io_bus.req_byte_addr[ADDR_W-1:1];
                        r_memRdEn      <= 1'b1;
                        r_reqReady     <= 1'b0;
                        r_busy         <= 1'b1;
                        r_state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_issueIdx == r_lastIdx) begin
                        r_memRdEn <= 1'b0;
                        r_state   <= DRAIN;
                    end else begin
                        r_issueIdx <= r_issueIdx + 2'd1;
                        r_memAddr  <= r_memAddr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_lastCapture) begin
                        r_wordData       <= r_littleEndian ? w_leWord : w_beWord;
                        r_wordMisaligned <= r_offset;
                        r_wordValid      <= 1'b1;
                        r_state          <= DONE;
                    end
                end
                DONE: begin
                    r_wordValid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_reqReady  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.req_ready       = r_reqReady;
    assign io_bus.mem_addr        = r_memAddr;
    assign io_bus.mem_rd_en       = r_memRdEn;
    assign io_bus.word_data       = r_wordData;
    assign io_bus.word_valid      = r_wordValid;
    assign io_bus.word_misaligned = r_wordMisaligned;
    assign io_bus.busy            = r_busy;
endmodule

// File: tb/tb_mem_word_assembler.sv
// Scoreboard bench for mem_word_assembler: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each backed by a RAM model whose byte i holds the value i.
module tb_mem_word_assembler;
    typedef struct {
        logic [31:0] data;
        logic        mis;
        int          cyc;
    } expT;

    logic clk;
    logic rst;
    int   cycleCnt   = 0;
    int   compareCnt = 0;
    int   failCnt    = 0;

    expT         expA[$];
    expT         expB[$];
    logic [6:0]  addrA[$];
    logic [6:0]  addrB[$];

    logic [15:0] ramA;
    logic [15:0] ramB [3];

    mem_word_assembler_if #(.ADDR_W(8)) ifA ();
    mem_word_assembler_if #(.ADDR_W(8)) ifB ();

    mem_word_assembler #(.ADDR_W(8), .MEM_LAT(1)) dutA (.clk(clk), .rst(rst), .io_bus(ifA.slave));
    mem_word_assembler #(.ADDR_W(8), .MEM_LAT(3)) dutB (.clk(clk), .rst(rst), .io_bus(ifB.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    function automatic logic [15:0] ramWord(input logic [6:0] h);
        logic [7:0] b;
        b = {h, 1'b0};
        return {b, b + 8'd1};
    endfunction

    // RAM models: data for the address presented in cycle n is visible during cycle n+MEM_LAT.
    always @(posedge clk) begin
        ramA    <= ramWord(ifA.mem_addr);
        ramB[0] <= ramWord(ifB.mem_addr);
        ramB[1] <= ramB[0];
        ramB[2] <= ramB[1];
    end
    assign ifA.mem_read_data = ramA;
    assign ifB.mem_read_data = ramB[2];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCnt++;
        if (actual !== expected) begin
            failCnt++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name);
        compareCnt++;
        failCnt++;
        $display("[TB] FAIL %s: event seen with nothing expected", name);
    endtask

    // Monitors pop the scoreboard whenever a DUT presents a RAM read or a completed word.
    always @(negedge clk) begin
        if (ifA.mem_rd_en === 1'b1) begin
            if (addrA.size() == 0) reportUnexpected("A mem_rd_en");
            else checkOutput("A mem_addr", 32'(ifA.mem_addr), 32'(addrA.pop_front()));
        end
        if (ifA.word_valid === 1'b1) begin
            if (expA.size() == 0) reportUnexpected("A word_valid");
            else begin
                expT e;
                e = expA.pop_front();
                checkOutput("A word_data", ifA.word_data, e.data);
                checkOutput("A word_misaligned", 32'(ifA.word_misaligned), 32'(e.mis));
                checkOutput("A latency cycle", 32'(cycleCnt), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (ifB.mem_rd_en === 1'b1) begin
            if (addrB.size() == 0) reportUnexpected("B mem_rd_en");
            else checkOutput("B mem_addr", 32'(ifB.mem_addr), 32'(addrB.pop_front()));
        end
        if (ifB.word_valid === 1'b1) begin
            if (expB.size() == 0) reportUnexpected("B word_valid");
            else begin
                expT e;
                e = expB.pop_front();
                checkOutput("B word_data", ifB.word_data, e.data);
                checkOutput("B word_misaligned", 32'(ifB.word_misaligned), 32'(e.mis));
                checkOutput("B latency cycle", 32'(cycleCnt), 32'(e.cyc));
            end
        end
    end

    // mode 0: plain request; mode 1: keep req_valid high into DRAIN with a new address;
    // mode 2: request that will be aborted by reset, so no word is expected.
    task automatic applyStimulus(input int dut, input logic [7:0] addr, input logic le,
                                 input logic [31:0] expData, input int mode);
        int         waited;
        int         acc;
        int         n;
        int         lat;
        logic [6:0] h;
        expT        e;
        waited = 0;
        @(negedge clk);
        while (((dut == 0) ? ifA.req_ready : ifB.req_ready) !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            compareCnt++;
            failCnt++;
            $display("[TB] FAIL req_ready timeout: dut %0d never ready, wanted ready within 50 cycles", dut);
            return;
        end
        if (dut == 0) begin
            ifA.req_valid = 1'b1; ifA.req_byte_addr = addr; ifA.req_little_endian = le;
        end else begin
            ifB.req_valid = 1'b1; ifB.req_byte_addr = addr; ifB.req_little_endian = le;
        end
        @(posedge clk);
        #1;
        acc = cycleCnt;
        n   = addr[0] ? 3 : 2;
        lat = (dut == 0) ? 1 : 3;
        h   = addr[7:1];
        for (int k = 0; k < n; k++) begin
            if (dut == 0) addrA.push_back(h + 7'(k));
            else          addrB.push_back(h + 7'(k));
        end
        if (mode != 2) begin
            e.data = expData;
            e.mis  = addr[0];
            e.cyc  = acc + n + lat;
            if (dut == 0) expA.push_back(e);
            else          expB.push_back(e);
        end
        if (dut == 0) begin
            checkOutput("A req_ready after accept", 32'(ifA.req_ready), 32'd0);
            checkOutput("A busy after accept", 32'(ifA.busy), 32'd1);
            ifA.req_byte_addr = (mode == 1) ? addr + 8'h10 : ~addr;
            ifA.req_little_endian = ~le;
            if (mode != 1) ifA.req_valid = 1'b0;
        end else begin
            checkOutput("B req_ready after accept", 32'(ifB.req_ready), 32'd0);
            checkOutput("B busy after accept", 32'(ifB.busy), 32'd1);
            ifB.req_byte_addr = ~addr;
            ifB.req_little_endian = ~le;
            ifB.req_valid = 1'b0;
        end
        if (mode == 1) begin
            repeat (2) @(posedge clk);
            #1;
            ifA.req_valid = 1'b0;
        end
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        ifA.req_valid = 1'b0; ifA.req_byte_addr = '0; ifA.req_little_endian = 1'b0;
        ifB.req_valid = 1'b0; ifB.req_byte_addr = '0; ifB.req_little_endian = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset req_ready", 32'(ifA.req_ready), 32'd1);
        checkOutput("reset busy", 32'(ifA.busy), 32'd0);
        checkOutput("reset word_valid", 32'(ifA.word_valid), 32'd0);
        checkOutput("reset word_data", ifA.word_data, 32'd0);
        checkOutput("reset word_misaligned", 32'(ifA.word_misaligned), 32'd0);
        checkOutput("reset mem_rd_en", 32'(ifA.mem_rd_en), 32'd0);
        checkOutput("reset mem_addr", 32'(ifA.mem_addr), 32'd0);
        checkOutput("B reset req_ready", 32'(ifB.req_ready), 32'd1);
        rst = 1'b0;

        applyStimulus(0, 8'h00, 1'b0, 32'h00010203, 0);
        applyStimulus(0, 8'h04, 1'b1, 32'h07060504, 0);
        applyStimulus(0, 8'h05, 1'b0, 32'h05060708, 0);
        applyStimulus(0, 8'h05, 1'b1, 32'h08070605, 0);
        applyStimulus(0, 8'hFF, 1'b0, 32'hFF000102, 0);
        applyStimulus(0, 8'h10, 1'b0, 32'h10111213, 1);

        // Abort an addr 0x08 read with reset sampled at the end of cycle 2.
        applyStimulus(0, 8'h08, 1'b0, 32'h0, 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort req_ready", 32'(ifA.req_ready), 32'd1);
        checkOutput("abort busy", 32'(ifA.busy), 32'd0);
        checkOutput("abort word_data", ifA.word_data, 32'd0);
        checkOutput("abort word_valid", 32'(ifA.word_valid), 32'd0);
        repeat (8) @(posedge clk);
        applyStimulus(0, 8'h08, 1'b0, 32'h08090A0B, 0);

        applyStimulus(1, 8'h00, 1'b0, 32'h00010203, 0);
        applyStimulus(1, 8'h05, 1'b1, 32'h08070605, 0);

        waited = 0;
        while ((expA.size() != 0 || expB.size() != 0 || addrA.size() != 0 || addrB.size() != 0) && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        repeat (4) @(posedge clk);
        if (expA.size() != 0 || expB.size() != 0 || addrA.size() != 0 || addrB.size() != 0) begin
            compareCnt++;
            failCnt++;
            $display("[TB] FAIL drain: %0d words and %0d reads still pending, wanted 0",
                     expA.size() + expB.size(), addrA.size() + addrB.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
        $finish;
    end
endmodule

// File: doc/mem_word_assembler.md
Name: mem_word_assembler

Overview:
Read sequencer and word assembler that sits directly downstream of the 16-bit halfword RAM. It takes a byte-addressed 32-bit read request, for example from the address switches, and issues 2 halfword reads (aligned) or 3 halfword reads (odd byte address). It then assembles the 4 addressed bytes into a 32-bit word in big- or little-endian order for the 8-digit display. It handles RAM read latency, address wrap-around and misalignment.

Parameters:
ADDR_W, 8, byte-address width; RAM halfword address width is ADDR_W-1.
MEM_LAT, 1, RAM read latency in cycles, range 1..3. Data for the mem_addr driven during cycle n is sampled at the end of cycle n+MEM_LAT.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  read request strobe
req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready at a rising edge
req_byte_addr  input  ADDR_W  byte address of the first byte of the word
req_little_endian  input  1  1 = little-endian assembly, 0 = big-endian; sampled on accept
mem_addr  output  ADDR_W-1  halfword address to the RAM (registered)
mem_rd_en  output  1  high in every cycle a valid mem_addr is presented
mem_read_data  input  16  RAM read data; byte 2h in [15:8], byte 2h+1 in [7:0]
word_data  output  32  assembled word, held until the next completion
word_valid  output  1  one-cycle completion pulse
word_misaligned  output  1  registered with word_data: 1 if req_byte_addr[0] was 1
busy  output  1  high from the cycle after accept through the word_valid cycle

Behaviour:
- Reset: all outputs 0 except req_ready=1. State IDLE; capture registers and the in-flight tag pipeline are cleared.
- Reset mid-operation: abort immediately to IDLE. No word_valid is produced. RAM data still in flight is discarded.
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- On accept (cycle 0): latch A=req_byte_addr, endian bit, and N = 2 if A[0]=0 else 3. h0 = A>>1.
- ISSUE: in cycles 1..N, drive mem_addr = h0+k for k=0..N-1 back-to-back with mem_rd_en=1.
  - Halfword address addition is modulo 2^(ADDR_W-1), so the top byte wraps to address 0.
- A MEM_LAT-deep valid/index tag pipeline follows the issues. Halfword k is captured at the end of cycle 1+k+MEM_LAT.
- DRAIN: mem_rd_en=0 and mem_addr holds its last value. Exit DRAIN when the last capture is done.
- DONE (cycle N+MEM_LAT+1): update word_data and word_misaligned; word_valid=1 for this cycle only. Next cycle is IDLE.
- Byte selection: captured bytes form the stream b0..b(2N-1). Use offset o=A[0]; the word bytes are B0..B3 = b(o)..b(o+3).
  - Big-endian: word_data = {B0,B1,B2,B3}.
  - Little-endian: word_data = {B3,B2,B1,B0}.
- Latency from accept to word_valid: N+MEM_LAT+1 cycles. Aligned with MEM_LAT=1: cycle 4. Misaligned: cycle 5.
- Back-pressure: req_ready=0 in ISSUE, DRAIN and DONE. req_valid in those states is ignored; nothing is queued.
- req_little_endian or req_byte_addr changing after accept has no effect on the current word.
- word_data is never partially updated; intermediate captures live in internal registers only.

Test Plan:
RAM preloaded so that halfword h = {8'(2h), 8'(2h+1)}, i.e. byte i = i, with ADDR_W=8.
- Aligned BE: addr 0x00, endian 0, MEM_LAT=1 -> mem_addr 0,1 in cycles 1-2; word_valid in cycle 4; word_data=0x00010203, misaligned=0.
- Aligned LE: addr 0x04, endian 1 -> word_data=0x07060504, misaligned=0.
- Misaligned: addr 0x05, BE -> 3 reads (h 2,3,4), word_valid in cycle 5, word_data=0x05060708, misaligned=1. Same address LE -> 0x08070605.
- Wrap-around: addr 0xFF, BE -> mem_addr 127,0,1; word_data=0xFF000102, misaligned=1.
- Busy/back-pressure and latency parameter: hold req_valid=1 with addr 0x10 and change it to 0x20 during ISSUE -> one completion with 0x10111213. With MEM_LAT=3, addr 0x00 -> word_valid in cycle 6.
- Reset mid-op: assert rst in cycle 2 of an addr 0x08 read -> next cycle req_ready=1, busy=0, word_valid never pulses, word_data=0. A following addr 0x08 read returns 0x08090A0B.
